ctrl_pipe: RTL and testbench

- Consumer end of the main decoder's control bundle: ALUOp, ALUSrc, Mem and WB.
- Carries the bundle from ID through the ID/EX, EX/MEM and MEM/WB stage registers and decodes it into per-stage strobes.
- Detects load-use hazards and requests a one-cycle stall, inserting a bubble into EX.
- Honours branch flushes and keeps retired-instruction and stall-bubble counters for performance checks.

---
 rtl/ctrl_pipe.sv | 153 +++++++++++++++
 tb/tb_ctrl_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoder control bundle through EX, MEM and WB,
// decodes per-stage strobes, detects load-use stalls and counts retires/bubbles.
module ctrl_pipe #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             id_valid_i,
    input  logic [1:0]       id_alu_op_i,
    input  logic             id_alu_src_i,
    input  logic [1:0]       id_mem_i,
    input  logic             id_wb_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       id_rd_i,
    output logic             hazard_stall_o,
    output logic             ex_valid_o,
    output logic [1:0]       ex_alu_op_o,
    output logic             ex_alu_src_o,
    output logic [4:0]       ex_rd_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             mem_reg_write_o,
    output logic [4:0]       mem_rd_o,
    output logic             wb_reg_write_o,
    output logic             wb_mem_to_reg_o,
    output logic [4:0]       wb_rd_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    typedef struct packed {
        logic       valid;
        logic [1:0] alu_op;
        logic       alu_src;
        logic [1:0] mem;
        logic       wb;
        logic [4:0] rd;
    } ex_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] mem;
        logic       wb;
        logic [4:0] rd;
    } mw_t;

    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    ex_t id_bundle;
    ex_t ex_d;
    ex_t ex_q;
    mw_t mem_d;
    mw_t mem_q;
    mw_t wb_d;
    mw_t wb_q;

    logic [CNT_W-1:0] retire_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;

    logic load_in_ex;
    logic src_match;
    logic hazard;

    // Gather the decoder outputs into the EX bundle layout
    always_comb begin
        id_bundle         = '0;
        id_bundle.valid   = id_valid_i;
        id_bundle.alu_op  = id_alu_op_i;
        id_bundle.alu_src = id_alu_src_i;
        id_bundle.mem     = id_mem_i;
        id_bundle.wb      = id_wb_i;
        id_bundle.rd      = id_rd_i;
    end

    // Load-use check; a flushed consumer is squashed anyway, so no stall
    always_comb begin
        load_in_ex = ex_q.valid
                   && (ex_q.mem == MEM_LOAD)
                   && (ex_q.rd != 5'd0);
        src_match  = (id_rs1_i == ex_q.rd)
                   || (id_rs2_used_i && (id_rs2_i == ex_q.rd));
        hazard     = id_valid_i && load_in_ex && src_match && !flush_i;
    end

    // Advance every stage; EX takes a zeroed bubble on stall, flush or empty ID
    always_comb begin
        ex_d = id_bundle;
        if (hazard || flush_i || !id_valid_i) begin
            ex_d = '0;
        end

        mem_d       = '0;
        mem_d.valid = ex_q.valid;
        mem_d.mem   = ex_q.mem;
        mem_d.wb    = ex_q.wb;
        mem_d.rd    = ex_q.rd;

        wb_d = mem_q;

        retire_cnt_d = retire_cnt_q;
        if (wb_q.valid) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end

        bubble_cnt_d = bubble_cnt_q;
        if (hazard) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // Stage registers and counters with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            retire_cnt_q <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            wb_q         <= wb_d;
            retire_cnt_q <= retire_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign hazard_stall_o  = hazard;

    assign ex_valid_o      = ex_q.valid;
    assign ex_alu_op_o     = ex_q.alu_op;
    assign ex_alu_src_o    = ex_q.alu_src;
    assign ex_rd_o         = ex_q.rd;

    assign mem_read_o      = mem_q.valid && (mem_q.mem == MEM_LOAD);
    assign mem_write_o     = mem_q.valid && (mem_q.mem == MEM_STORE);
    assign mem_reg_write_o = mem_q.valid && mem_q.wb && (mem_q.rd != 5'd0);
    assign mem_rd_o        = mem_q.rd;

    assign wb_reg_write_o  = wb_q.valid && wb_q.wb && (wb_q.rd != 5'd0);
    assign wb_mem_to_reg_o = wb_q.valid && (wb_q.mem == MEM_LOAD);
    assign wb_rd_o         = wb_q.rd;

    assign retire_cnt_o    = retire_cnt_q;
    assign bubble_cnt_o    = bubble_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scenarios plus randomized traffic checked
// against a cycle-history model of the control pipeline.
module tb_ctrl_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       flush;
    logic       id_valid;
    logic [1:0] alu_op;
    logic       alu_src;
    logic [1:0] mem;
    logic       wb;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs2u;
    logic [4:0] rd;

    logic        haz, exv, exsrc, mrd, mwr, mrw, wrw, wm2r;
    logic [1:0]  exop;
    logic [4:0]  exrd, mrdx, wrd;
    logic [31:0] rcnt, bcnt;

    logic        q_haz, q_exv, q_exsrc, q_mrd, q_mwr, q_mrw, q_wrw, q_wm2r;
    logic [1:0]  q_exop;
    logic [4:0]  q_exrd, q_mrdx, q_wrd;
    logic [3:0]  q_rcnt, q_bcnt;

    ctrl_pipe #(.CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
        .id_valid_i(id_valid), .id_alu_op_i(alu_op),
        .id_alu_src_i(alu_src), .id_mem_i(mem), .id_wb_i(wb),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs2_used_i(rs2u),
        .id_rd_i(rd), .hazard_stall_o(haz), .ex_valid_o(exv),
        .ex_alu_op_o(exop), .ex_alu_src_o(exsrc), .ex_rd_o(exrd),
        .mem_read_o(mrd), .mem_write_o(mwr),
        .mem_reg_write_o(mrw), .mem_rd_o(mrdx),
        .wb_reg_write_o(wrw), .wb_mem_to_reg_o(wm2r),
        .wb_rd_o(wrd), .retire_cnt_o(rcnt), .bubble_cnt_o(bcnt)
    );

    ctrl_pipe #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
        .id_valid_i(id_valid), .id_alu_op_i(alu_op),
        .id_alu_src_i(alu_src), .id_mem_i(mem), .id_wb_i(wb),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs2_used_i(rs2u),
        .id_rd_i(rd), .hazard_stall_o(q_haz), .ex_valid_o(q_exv),
        .ex_alu_op_o(q_exop), .ex_alu_src_o(q_exsrc), .ex_rd_o(q_exrd),
        .mem_read_o(q_mrd), .mem_write_o(q_mwr),
        .mem_reg_write_o(q_mrw), .mem_rd_o(q_mrdx),
        .wb_reg_write_o(q_wrw), .wb_mem_to_reg_o(q_wm2r),
        .wb_rd_o(q_wrd), .retire_cnt_o(q_rcnt), .bubble_cnt_o(q_bcnt)
    );

    typedef struct packed {
        logic       v;
        logic [1:0] op;
        logic       src;
        logic [1:0] mem;
        logic       wb;
        logic [4:0] rd;
    } ent_t;

    // age[k] = instruction that entered EX k cycles ago (0 = EX, 1 = MEM, 2 = WB)
    ent_t        age [3];
    int unsigned m_ret;
    int unsigned m_bub;
    int          n_chk;
    int          n_err;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic m_haz();
        ent_t e = age[0];
        return id_valid && !flush && e.v && e.mem == 2'b01
            && e.rd != 5'd0
            && (rs1 == e.rd || (rs2u && rs2 == e.rd));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) age[i] = '0;
        m_ret = 0;
        m_bub = 0;
    endtask

    task automatic model_step();
        ent_t e;
        logic h;
        h = m_haz();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (age[2].v) m_ret++;
            if (h) m_bub++;
            e = '0;
            if (id_valid && !flush && !h) begin
                e.v   = 1'b1;
                e.op  = alu_op;
                e.src = alu_src;
                e.mem = mem;
                e.wb  = wb;
                e.rd  = rd;
            end
            age[2] = age[1];
            age[1] = age[0];
            age[0] = e;
        end
    endtask

    task automatic compare_all();
        check("stall", haz, m_haz());
        check("ex_valid", exv, age[0].v);
        check("ex_alu_op", exop, age[0].op);
        check("ex_alu_src", exsrc, age[0].src);
        check("ex_rd", exrd, age[0].rd);
        check("mem_read", mrd, age[1].v && age[1].mem == 2'b01);
        check("mem_write", mwr, age[1].v && age[1].mem == 2'b10);
        check("mem_reg_write", mrw,
              age[1].v && age[1].wb && age[1].rd != 0);
        check("mem_rd", mrdx, age[1].rd);
        check("wb_reg_write", wrw,
              age[2].v && age[2].wb && age[2].rd != 0);
        check("wb_mem_to_reg", wm2r, age[2].v && age[2].mem == 2'b01);
        check("wb_rd", wrd, age[2].rd);
        check("retire_cnt", rcnt, m_ret);
        check("bubble_cnt", bcnt, m_bub);
        check("retire_cnt4", q_rcnt, m_ret % 16);
        check("bubble_cnt4", q_bcnt, m_bub % 16);
        check("stall4", q_haz, m_haz());
    endtask

    task automatic tick();
        compare_all();
        model_step();
        @(negedge clk);
    endtask

    task automatic drv(input logic v, input logic [1:0] op,
                       input logic src, input logic [1:0] m,
                       input logic w, input logic [4:0] r1,
                       input logic [4:0] r2, input logic u,
                       input logic [4:0] d, input logic f);
        id_valid = v;
        alu_op   = op;
        alu_src  = src;
        mem      = m;
        wb       = w;
        rs1      = r1;
        rs2      = r2;
        rs2u     = u;
        rd       = d;
        flush    = f;
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] tbl [4];
        tbl[0] = 5'd0;
        tbl[1] = 5'd5;
        tbl[2] = 5'd6;
        tbl[3] = 5'd7;
        return tbl[$urandom_range(0, 3)];
    endfunction

    logic [31:0] snap;
    logic        hold;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        // reset state
        idle();
        check("rst_ex_valid", exv, 0);
        check("rst_wb_rd", wrd, 0);
        check("rst_retire", rcnt, 0);
        tick();

        // load-use on rs1
        drv(1, 0, 1, 2'b01, 1, 1, 0, 0, 5, 0);
        tick();
        drv(1, 2, 0, 2'b00, 1, 5, 1, 1, 6, 0);
        check("lu_stall", haz, 1);
        check("lu_ex_lw", exv, 1);
        tick();
        drv(1, 2, 0, 2'b00, 1, 5, 1, 1, 6, 0);
        check("lu_stall_once", haz, 0);
        check("lu_bubble", exv, 0);
        check("lu_mem_read", mrd, 1);
        check("lu_bcnt", bcnt, 1);
        tick();
        idle();
        check("lu_add_ex", exv, 1);
        check("lu_add_rd", exrd, 6);
        tick();
        for (int i = 0; i < 3; i++) begin idle(); tick(); end

        // store reading the load result through rs2
        drv(1, 0, 1, 2'b01, 1, 1, 0, 0, 5, 0);
        tick();
        drv(1, 0, 1, 2'b10, 0, 2, 5, 1, 7, 0);
        check("sw_stall", haz, 1);
        tick();
        drv(1, 0, 1, 2'b10, 0, 2, 5, 1, 7, 0);
        check("sw_stall_once", haz, 0);
        tick();
        idle();
        tick();
        idle();
        check("sw_mem_write", mwr, 1);
        tick();
        idle();
        check("sw_no_wb", wrw, 0);
        check("sw_wb_rd", wrd, 7);
        tick();
        drv(1, 0, 1, 2'b01, 1, 1, 0, 0, 5, 0);
        tick();
        drv(1, 0, 1, 2'b10, 0, 2, 5, 0, 7, 0);
        check("sw_rs2_unused", haz, 0);
        tick();
        for (int i = 0; i < 3; i++) begin idle(); tick(); end

        // writes to x0
        drv(1, 0, 1, 2'b00, 1, 0, 0, 0, 0, 0);
        tick();
        idle(); tick();
        idle(); tick();
        idle();
        check("x0_wb", wrw, 0);
        snap = rcnt;
        tick();
        idle();
        check("x0_retire", rcnt, snap + 1);
        tick();
        drv(1, 0, 1, 2'b01, 1, 1, 0, 0, 0, 0);
        tick();
        drv(1, 0, 0, 2'b00, 1, 0, 0, 1, 6, 0);
        check("x0_nostall", haz, 0);
        tick();
        for (int i = 0; i < 3; i++) begin idle(); tick(); end

        // flush overrides a load-use hazard
        drv(1, 0, 1, 2'b01, 1, 1, 0, 0, 5, 0);
        tick();
        snap = bcnt;
        drv(1, 2, 0, 2'b00, 1, 5, 0, 0, 9, 1);
        check("fl_stall", haz, 0);
        tick();
        idle();
        check("fl_bubble", exv, 0);
        check("fl_bcnt", bcnt, snap);
        tick();
        for (int i = 0; i < 4; i++) begin
            idle();
            check("fl_never_wb", wrd == 5'd9, 0);
            tick();
        end

        // reset with three loads in flight
        drv(1, 0, 1, 2'b01, 1, 0, 0, 0, 1, 0); tick();
        drv(1, 0, 1, 2'b01, 1, 0, 0, 0, 2, 0); tick();
        drv(1, 0, 1, 2'b01, 1, 0, 0, 0, 3, 0); tick();
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            check("rst_strobes",
                  {exv, mrd, mwr, mrw, wrw, wm2r}, 0);
            check("rst_counters", rcnt | bcnt, 0);
            tick();
        end

        // 17 retires wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            drv(1, 0, 1, 2'b00, 1, 0, 0, 0, 1, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin idle(); tick(); end
        idle();
        check("wrap4", q_rcnt, 1);
        check("wrap32", rcnt, 17);
        tick();

        // randomized traffic; a stalled instruction is re-presented
        hold = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            if (hold) begin
                flush = ($urandom_range(0, 7) == 0);
                #1;
            end else begin
                drv($urandom_range(0, 3) != 0,
                    2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    pick_reg(), pick_reg(),
                    1'($urandom_range(0, 1)),
                    pick_reg(),
                    $urandom_range(0, 7) == 0);
            end
            hold = m_haz() && rst_n;
            tick();
        end

        rst_n = 1'b1;
        idle();
        compare_all();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
